// File: rtl/sequence_generator_pkg.sv
// Shared definitions for the sequence generator: FSM state encoding and default sizing.
package sequence_generator_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DAT_W  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

endpackage

// File: rtl/sequence_generator_mem.sv
// Symbol store: DEPTH x DAT_W register file, one synchronous write port, one async read port.
module sequence_generator_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DAT_W  = 4
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DAT_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DAT_W-1:0]  rd_data
);

  // Contents are intentionally not reset; the length counter masks stale entries.
  logic [DAT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sequence_generator.sv
// Stores a list of symbols entered by LOAD strobes and replays them as CE-paced
// (DAT_O, STB_O) strobes, one-shot or looping.
module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DAT_W  = DEF_DAT_W
) (
  input  logic              CLK,
  input  logic              SYS_NRST,
  input  logic              CE,
  input  logic              LOAD,
  input  logic [DAT_W-1:0]  DAT_I,
  input  logic              START,
  input  logic              STOP,
  input  logic              CLR,
  input  logic              LOOP,
  output logic [DAT_W-1:0]  DAT_O,
  output logic              STB_O,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W:0]   LEN,
  output logic [ADDR_W-1:0] POS,
  output logic              FULL
);

  localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   pos_q, pos_d;
  logic [DAT_W-1:0]    dat_q, dat_d;
  logic                stb_q, stb_d;
  logic                done_q, done_d;

  logic                wr_en;
  logic [DAT_W-1:0]    rd_data;
  logic                full;
  logic                last_sym;

  sequence_generator_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DAT_W  (DAT_W)
  ) u_mem (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (len_q[ADDR_W-1:0]),
    .wr_data (DAT_I),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign full     = (len_q == LEN_FULL);
  assign last_sym = ({1'b0, rd_ptr_q} == (len_q - LEN_ONE));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    pos_d    = pos_q;
    dat_d    = dat_q;
    stb_d    = 1'b0;
    done_d   = 1'b0;
    wr_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // STOP outranks every other command, so it swallows the cycle even when idle.
        if (!STOP) begin
          if (CLR) begin
            len_d = '0;
          end else if (START) begin
            if (len_q != '0) begin
              rd_ptr_d = '0;
              state_d  = ST_PLAY;
            end
          end else if (LOAD && !full) begin
            wr_en = 1'b1;
            len_d = len_q + LEN_ONE;
          end
        end
      end

      ST_PLAY: begin
        if (STOP) begin
          state_d = ST_IDLE;
        end else if (CLR) begin
          state_d = ST_IDLE;
          len_d   = '0;
        end else if (CE) begin
          stb_d = 1'b1;
          dat_d = rd_data;
          pos_d = rd_ptr_q;
          if (last_sym) begin
            rd_ptr_d = '0;
            if (!LOOP) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      rd_ptr_q <= '0;
      pos_q    <= '0;
      dat_q    <= '0;
      stb_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rd_ptr_q <= rd_ptr_d;
      pos_q    <= pos_d;
      dat_q    <= dat_d;
      stb_q    <= stb_d;
      done_q   <= done_d;
    end
  end

  assign DAT_O = dat_q;
  assign STB_O = stb_q;
  assign BUSY  = (state_q == ST_PLAY);
  assign DONE  = done_q;
  assign LEN   = len_q;
  assign POS   = pos_q;
  assign FULL  = full;

endmodule

// File: tb/tb_sequence_generator.sv
// Vector table plus strobe scoreboard for sequence_generator; hand sequences cover full
// memory and asynchronous reset during replay.
module tb_sequence_generator;

  logic       CLK;
  logic       SYS_NRST;
  logic       CE, LOAD, START, STOP, CLR, LOOP;
  logic [3:0] DAT_I;
  logic [3:0] DAT_O;
  logic       STB_O, BUSY, DONE, FULL;
  logic [4:0] LEN;
  logic [3:0] POS;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         ce, load, start, stop, clr, loop;
    logic [3:0] dat;
    bit         exp_stb;
    logic [3:0] exp_dat;
    bit         exp_done;
    logic [3:0] exp_pos;
    bit         exp_busy;
    logic [4:0] exp_len;
  } vec_t;

  typedef struct packed {
    logic [3:0] dat;
    logic [3:0] pos;
    logic       done;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  sequence_generator dut (
    .CLK      (CLK),
    .SYS_NRST (SYS_NRST),
    .CE       (CE),
    .LOAD     (LOAD),
    .DAT_I    (DAT_I),
    .START    (START),
    .STOP     (STOP),
    .CLR      (CLR),
    .LOOP     (LOOP),
    .DAT_O    (DAT_O),
    .STB_O    (STB_O),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .LEN      (LEN),
    .POS      (POS),
    .FULL     (FULL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t v(input bit ce, input bit load, input bit start, input bit stop,
                             input bit clr, input bit loop, input int dat,
                             input bit stb, input int edat, input bit done, input int pos,
                             input bit busy, input int len);
    vec_t t;
    t.ce = ce; t.load = load; t.start = start; t.stop = stop; t.clr = clr; t.loop = loop;
    t.dat = 4'(dat);
    t.exp_stb = stb; t.exp_dat = 4'(edat); t.exp_done = done; t.exp_pos = 4'(pos);
    t.exp_busy = busy; t.exp_len = 5'(len);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of commands, then check outputs 1 time unit after the capturing edge.
  task automatic apply(input vec_t t);
    exp_t e;
    @(negedge CLK);
    CE = t.ce; LOAD = t.load; START = t.start; STOP = t.stop; CLR = t.clr; LOOP = t.loop;
    DAT_I = t.dat;
    if (t.exp_stb) begin
      e.dat = t.exp_dat; e.pos = t.exp_pos; e.done = t.exp_done;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    chk("stb_o", {31'd0, STB_O}, {31'd0, sb.size() != 0});
    if (STB_O && sb.size() != 0) begin
      e = sb.pop_front();
      chk("dat_o", {28'd0, DAT_O}, {28'd0, e.dat});
      chk("pos", {28'd0, POS}, {28'd0, e.pos});
      chk("done", {31'd0, DONE}, {31'd0, e.done});
      $display("strobe: DAT_O=%h POS=%0d DONE=%0b BUSY=%0b LEN=%0d", DAT_O, POS, DONE, BUSY, LEN);
    end else begin
      if (sb.size() != 0) void'(sb.pop_front());
      chk("done_without_strobe", {31'd0, DONE}, 32'd0);
    end
    chk("busy", {31'd0, BUSY}, {31'd0, t.exp_busy});
    chk("len", {27'd0, LEN}, {27'd0, t.exp_len});
    chk("full", {31'd0, FULL}, {31'd0, t.exp_len == 5'd16});
  endtask

  initial begin
    SYS_NRST = 1'b0;
    CE = 0; LOAD = 0; START = 0; STOP = 0; CLR = 0; LOOP = 0; DAT_I = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_dat_o", {28'd0, DAT_O}, 32'd0);
    chk("reset_stb_o", {31'd0, STB_O}, 32'd0);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    chk("reset_done", {31'd0, DONE}, 32'd0);
    chk("reset_len", {27'd0, LEN}, 32'd0);
    chk("reset_pos", {28'd0, POS}, 32'd0);
    @(negedge CLK);
    SYS_NRST = 1'b1;

    //                ce ld st sp cl lp dat   stb ed dn pos busy len
    // One-shot replay of 3,A,5
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 3,    0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 'hA, 0, 0, 0, 0, 0, 2));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 5,    0, 0, 0, 0, 0, 3));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0, 1, 3));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,    1, 3, 0, 0, 1, 3));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 3));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,    1, 'hA, 0, 1, 1, 3));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,    1, 5, 1, 2, 0, 3));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 3));
    // Looping replay of {1,2}, then STOP
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0,    0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 1,    0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 2,    0, 0, 0, 0, 0, 2));
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 0,    0, 0, 0, 0, 1, 2));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0,    1, 1, 0, 0, 1, 2));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0,    1, 2, 0, 1, 1, 2));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0,    1, 1, 0, 0, 1, 2));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0,    1, 2, 0, 1, 1, 2));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0,    1, 1, 0, 0, 1, 2));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 0,    0, 0, 0, 0, 0, 2));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0,    0, 0, 0, 0, 0, 2));
    // Empty START, CLR+LOAD, START+CE, LOAD in PLAY, LEN=1 one-shot
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0,    0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 6,    0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 7,    0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 9,    0, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,    1, 7, 1, 0, 0, 1));
    // CLR during PLAY wins over a same-cycle CE
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 8,    0, 0, 0, 0, 0, 2));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0, 1, 2));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,    1, 7, 0, 0, 1, 2));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0,    0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Fill all 16 entries, a 17th LOAD must neither store nor grow LEN.
    for (int i = 0; i < 17; i++) begin
      apply(v(0, 1, 0, 0, 0, 0, (i < 16) ? 15 - i : 0, 0, 0, 0, 0, 0, (i < 16) ? i + 1 : 16));
    end
    apply(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16));
    for (int i = 0; i < 16; i++) begin
      apply(v(1, 0, 0, 0, 0, 0, 0, 1, 15 - i, i == 15, i, i != 15, 16));
    end
    apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16));

    // Asynchronous reset in the middle of a looping replay.
    apply(v(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(v(0, 1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 1));
    apply(v(0, 1, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 2));
    apply(v(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2));
    apply(v(1, 0, 0, 0, 0, 1, 0, 1, 9, 0, 0, 1, 2));
    apply(v(1, 0, 0, 0, 0, 1, 0, 1, 4, 0, 1, 1, 2));
    #2;
    SYS_NRST = 1'b0;
    #1;
    chk("async_rst_dat_o", {28'd0, DAT_O}, 32'd0);
    chk("async_rst_pos", {28'd0, POS}, 32'd0);
    chk("async_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("async_rst_len", {27'd0, LEN}, 32'd0);
    @(negedge CLK);
    SYS_NRST = 1'b1;
    apply(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(v(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
